spi_reg_slave: RTL and testbench

//  SPI mode-0, write-only register-file slave. Sits directly upstream of the
//  PWM peripheral inside the project top and drives its five 8-bit config

---
 rtl/spi_reg_slave_pkg.sv | 17 +
 rtl/spi_reg_slave_if.sv | 23 ++
 rtl/spi_reg_slave_sync_edge.sv | 37 +++
 rtl/spi_reg_slave.sv | 135 +++++++++++++
 tb/tb_spi_reg_slave.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_slave_pkg.sv
// Shared constants and types for the SPI write-only register-file slave.
package spi_reg_pkg;

  localparam int unsigned ADDR_EN_OUT_LO = 'h00;
  localparam int unsigned ADDR_EN_OUT_HI = 'h01;
  localparam int unsigned ADDR_EN_PWM_LO = 'h02;
  localparam int unsigned ADDR_EN_PWM_HI = 'h03;
  localparam int unsigned ADDR_DUTY      = 'h04;
  localparam int unsigned FRAME_BITS     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } spi_state_e;

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pins plus the five configuration register outputs.
interface spi_reg_slave_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
           en_reg_pwm_15_8, pwm_duty_cycle
  );

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
           en_reg_pwm_15_8, pwm_duty_cycle
  );
endinterface

// File: rtl/spi_reg_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall pulses
// derived from the synchronised level only.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 write-only register file: 16-bit frames {wr, addr, data}
// commit one byte on chip-select release when exactly 16 bits were clocked.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7
) (
  input logic           clk,
  input logic           rst_n,
  spi_reg_slave_if.slave bus
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + 8;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam int unsigned SLOTS   = (NUM_REGS > 5) ? NUM_REGS : 5;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_pipe_q, rst_pipe_d;
  logic       rst_int_n;

  always_comb rst_pipe_d = {rst_pipe_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe_q <= '0;
    else        rst_pipe_q <= rst_pipe_d;
  end

  assign rst_int_n = rst_pipe_q[1];

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_int_n), .d_in(bus.sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_int_n), .d_in(bus.copi),
    .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_int_n), .d_in(bus.ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

  spi_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0]       sr_q, sr_d;
  logic                     pend_q, pend_d;
  logic [NUM_REGS*8-1:0]    regs_q, regs_d;
  logic                     start, shift_en, commit, wr_ok;
  logic [ADDR_W-1:0]        addr;
  logic [7:0]               data;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // A start pending from COMMIT is honoured on the next IDLE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ncs_fall || pend_q) state_d = SHIFT;
      SHIFT:   if (ncs_rise)           state_d = COMMIT;
      COMMIT:                          state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    start    = (state_q == IDLE) && (ncs_fall || pend_q);
    shift_en = (state_q == SHIFT) && sclk_rise && !ncs_lvl;
    commit   = (state_q == COMMIT);
    pend_d   = commit && ncs_fall;
  end

  assign addr  = sr_q[FRAME_W-2 -: ADDR_W];
  assign data  = sr_q[7:0];
  assign wr_ok = commit && (cnt_q == CNT_FULL) && sr_q[FRAME_W-1]
                 && (addr < ADDR_W'(NUM_REGS));

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (start) begin
      cnt_d = '0;
    end else if (shift_en) begin
      sr_d = {sr_q[FRAME_W-2:0], copi_lvl};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_ok && addr == ADDR_W'(i)) regs_d[i*8 +: 8] = data;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      pend_q <= 1'b0;
      regs_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      pend_q <= pend_d;
      regs_q <= regs_d;
    end
  end

  // Outputs beyond the implemented register count read as zero.
  logic [SLOTS*8-1:0] regs_pad;
  assign regs_pad = (SLOTS*8)'(regs_q);

  assign bus.en_reg_out_7_0  = regs_pad[ADDR_EN_OUT_LO*8 +: 8];
  assign bus.en_reg_out_15_8 = regs_pad[ADDR_EN_OUT_HI*8 +: 8];
  assign bus.en_reg_pwm_7_0  = regs_pad[ADDR_EN_PWM_LO*8 +: 8];
  assign bus.en_reg_pwm_15_8 = regs_pad[ADDR_EN_PWM_HI*8 +: 8];
  assign bus.pwm_duty_cycle  = regs_pad[ADDR_DUTY*8 +: 8];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a register-array model of the write rules
// checked every cycle, plus literal expectations after each scenario.
module tb_spi_reg_slave;

  localparam int unsigned SYNC = 2;
  localparam int unsigned LAT  = SYNC + 2;
  localparam time HALF = 40ns;

  logic clk = 1'b0;
  logic rst_n;
  always #5ns clk = ~clk;

  spi_reg_slave_if bus ();

  spi_reg_slave #(.SYNC_STAGES(SYNC), .NUM_REGS(5), .ADDR_W(7)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [7:0] exp_r [5];
  bit         model_valid = 1'b0;
  int         n_vec = 0;
  int         n_miss = 0;

  function automatic void model_clear();
    for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
  endfunction

  // Only an exact 16-bit write to an implemented address changes anything.
  function automatic void model_frame(input logic [31:0] bits, input int n);
    int a;
    a = int'(bits[14:8]);
    if (n == 16 && bits[15] == 1'b1 && a < 5) begin
      for (int i = 0; i < 5; i++) if (i == a) exp_r[i] = bits[7:0];
    end
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      logic [39:0] got, want;
      got  = {bus.en_reg_out_7_0, bus.en_reg_out_15_8, bus.en_reg_pwm_7_0,
              bus.en_reg_pwm_15_8, bus.pwm_duty_cycle};
      want = {exp_r[0], exp_r[1], exp_r[2], exp_r[3], exp_r[4]};
      n_vec++;
      if (got !== want) begin
        n_miss++;
        $display("FAIL cycle_regs t=%0t got=%h want=%h", $time, got, want);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic frame_body(input logic [31:0] bits, input int n);
    bus.ncs = 1'b0;
    #HALF;
    for (int i = n - 1; i >= 0; i--) begin
      bus.copi = bits[i];
      #HALF;
      bus.sclk = 1'b1;
      #HALF;
      bus.sclk = 1'b0;
    end
    #HALF;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    frame_body(bits, n);
    bus.ncs = 1'b1;
    model_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    model_frame(bits, n);
    model_valid = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out_lo"}, bus.en_reg_out_7_0, 8'h00);
    check({name, "_out_hi"}, bus.en_reg_out_15_8, 8'h00);
    check({name, "_pwm_lo"}, bus.en_reg_pwm_7_0, 8'h00);
    check({name, "_pwm_hi"}, bus.en_reg_pwm_15_8, 8'h00);
    check({name, "_duty"}, bus.pwm_duty_cycle, 8'h00);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: random pin activity, then reset asserted in the middle of it
    repeat (60) begin
      @(negedge clk);
      bus.sclk = 1'($urandom);
      bus.copi = 1'($urandom);
      bus.ncs  = 1'($urandom);
    end
    rst_n = 1'b0;
    #1ns;
    check_all_zero("rst_assert");
    repeat (5) begin
      @(negedge clk);
      bus.sclk = 1'($urandom);
      bus.copi = 1'($urandom);
      bus.ncs  = 1'($urandom);
    end
    check_all_zero("rst_held");
    bus.sclk = 1'b0;
    bus.ncs  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    model_clear();
    model_valid = 1'b1;

    // 2: write addr 0
    send_frame(32'h80F0, 16);
    check("wr0_out_lo", bus.en_reg_out_7_0, 8'hF0);
    check("wr0_duty", bus.pwm_duty_cycle, 8'h00);

    // 3: duty write, then out-of-range addresses
    send_frame(32'h84C0, 16);
    check("wr4_duty", bus.pwm_duty_cycle, 8'hC0);
    send_frame(32'h85AA, 16);
    send_frame(32'hFF11, 16);
    check("oor_duty", bus.pwm_duty_cycle, 8'hC0);
    check("oor_out_lo", bus.en_reg_out_7_0, 8'hF0);

    // 4: read frame is ignored
    send_frame(32'h0055, 16);
    check("rd_out_lo", bus.en_reg_out_7_0, 8'hF0);

    // 5: short frame (shift reg would hold 0x8133) and long frame, then exact
    send_frame(32'h0133, 15);
    check("short_out_hi", bus.en_reg_out_15_8, 8'h00);
    send_frame(32'h18133, 17);
    check("long_out_hi", bus.en_reg_out_15_8, 8'h00);
    send_frame(32'h8133, 16);
    check("exact_out_hi", bus.en_reg_out_15_8, 8'h33);

    // 6: reset after 8 bits of 0x8280, then a clean frame with latency bound
    frame_body(32'h82, 8);
    rst_n = 1'b0;
    model_valid = 1'b0;
    model_clear();
    #1ns;
    check_all_zero("midframe_rst");
    bus.ncs  = 1'b1;
    bus.sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    model_valid = 1'b1;

    frame_body(32'h8380, 16);
    bus.ncs = 1'b1;
    model_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1ns;
      if (bus.en_reg_pwm_15_8 === 8'h80) begin
        lat = c;
        break;
      end
    end
    n_vec++;
    if (lat == 0 || lat > int'(LAT)) begin
      n_miss++;
      $display("FAIL latency got=%0d want=1..%0d", lat, LAT);
    end
    model_frame(32'h8380, 16);
    model_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_pwm_hi", bus.en_reg_pwm_15_8, 8'h80);
    check("post_rst_pwm_lo", bus.en_reg_pwm_7_0, 8'h00);
    check("post_rst_out_lo", bus.en_reg_out_7_0, 8'h00);

    repeat (8) @(negedge clk);
    model_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
